// File: rtl/fruit_launcher_if.sv
// Launcher-to-motion-slot init bundle.
// Is_Bomb exists only when LAUNCHER_BOMB_EN is defined.
interface fruit_launcher_if #(
  parameter int NUM_SLOTS = 4
);
  logic [NUM_SLOTS-1:0] out_of_screen;
  logic [NUM_SLOTS-1:0] Initialize;
  logic signed [31:0]   X_Pos_Init;
  logic signed [31:0]   Y_Pos_Init;
  logic signed [31:0]   X_V_Init;
  logic signed [31:0]   Y_V_Init;
  logic [2:0]           Fruit_Type;
`ifdef LAUNCHER_BOMB_EN
  logic                 Is_Bomb;
`endif

  modport master (
`ifdef LAUNCHER_BOMB_EN
    output Is_Bomb,
`endif
    input  out_of_screen,
    output Initialize,
    output X_Pos_Init,
    output Y_Pos_Init,
    output X_V_Init,
    output Y_V_Init,
    output Fruit_Type
  );

  modport slave (
`ifdef LAUNCHER_BOMB_EN
    input  Is_Bomb,
`endif
    output out_of_screen,
    input  Initialize,
    input  X_Pos_Init,
    input  Y_Pos_Init,
    input  X_V_Init,
    input  Y_V_Init,
    input  Fruit_Type
  );
endinterface

// File: rtl/fruit_launcher.sv
// Fruit launch scheduler: picks a free slot, randomizes, issues init.
// Optional bomb launches: define LAUNCHER_BOMB_EN.
module fruit_launcher #(
  parameter int          NUM_SLOTS         = 4,
  parameter int          FRUIT_WIDTH_HALF  = 32,
  parameter int          FRUIT_HEIGHT_HALF = 32,
  parameter int          VY_MIN            = 9,
  parameter int          GAP_MIN           = 20,
  parameter int          NUM_TYPES         = 4,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk_rising_edge,
  input  logic             Launch_En,
  fruit_launcher_if.master lif,
  output logic [15:0]      Launch_Count
);

  localparam int SW   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int SW1  = SW + 1;
  localparam int SPAN = 640 - 2 * FRUIT_WIDTH_HALF;

  typedef enum logic [1:0] {
    IDLE,
    PICK,
    LOAD,
    ISSUE
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [15:0]          gap_q, gap_d;
  logic [15:0]          count_q, count_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [SW-1:0]        rr_q, rr_d;
  logic [3:0]           lgap_q, lgap_d;
  logic [NUM_SLOTS-1:0] init_q, init_d;
  logic signed [31:0]   x_q, x_d;
  logic signed [31:0]   y_q, y_d;
  logic signed [31:0]   xv_q, xv_d;
  logic signed [31:0]   yv_q, yv_d;
  logic [2:0]           type_q, type_d;
`ifdef LAUNCHER_BOMB_EN
  logic                 bomb_q, bomb_d;
`endif

  logic          hit;
  logic [SW-1:0] hit_idx;
  logic [SW:0]   sum;
  int            xpos;
  int            mag;

  // First free slot at or after the round-robin pointer.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    sum     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      sum = {1'b0, rr_q} + SW1'(i);
      if (sum >= SW1'(NUM_SLOTS))
        sum = sum - SW1'(NUM_SLOTS);
      if (!hit && lif.out_of_screen[sum[SW-1:0]]) begin
        hit     = 1'b1;
        hit_idx = sum[SW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    count_d  = count_q;
    slot_d   = slot_q;
    rr_d     = rr_q;
    lgap_d   = lgap_q;
    init_d   = init_q;
    x_d      = x_q;
    y_d      = y_q;
    xv_d     = xv_q;
    yv_d     = yv_q;
    type_d   = type_q;
`ifdef LAUNCHER_BOMB_EN
    bomb_d   = bomb_q;
`endif
    lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400)
                         : (lfsr_q >> 1);
    xpos     = FRUIT_WIDTH_HALF
             + (int'(lfsr_q[9:0]) % SPAN);
    mag      = 1 + int'(lfsr_q[14:13]);

    unique case (state_q)
      IDLE: begin
        if (gap_q != 16'd0) begin
          if (frame_clk_rising_edge)
            gap_d = gap_q - 16'd1;
        end else if (Launch_En) begin
          state_d = PICK;
        end
      end
      PICK: begin
        if (hit) begin
          slot_d  = hit_idx;
          state_d = LOAD;
        end else begin
          gap_d   = 16'd0;
          state_d = IDLE;
        end
      end
      LOAD: begin
        x_d    = xpos;
        y_d    = 479 + FRUIT_HEIGHT_HALF;
        xv_d   = (xpos < 320) ? mag : -mag;
        yv_d   = -(VY_MIN + int'(lfsr_q[12:10]));
        type_d = 3'(int'(lfsr_q[15:13]) % NUM_TYPES);
`ifdef LAUNCHER_BOMB_EN
        bomb_d = (lfsr_q[7:5] == 3'b000);
        if (bomb_d)
          type_d = 3'd0;
`endif
        lgap_d         = lfsr_q[3:0];
        init_d         = '0;
        init_d[slot_q] = 1'b1;
        state_d        = ISSUE;
      end
      ISSUE: begin
        // Only an edge seen with Initialize already high is a handshake.
        if (frame_clk_rising_edge) begin
          init_d  = '0;
          count_d = count_q + 16'd1;
          rr_d    = (slot_q == SW'(NUM_SLOTS - 1))
                  ? '0 : slot_q + 1'b1;
          gap_d   = 16'(GAP_MIN) + {12'd0, lgap_q};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      gap_q   <= '0;
      count_q <= '0;
      slot_q  <= '0;
      rr_q    <= '0;
      lgap_q  <= '0;
      init_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      xv_q    <= '0;
      yv_q    <= '0;
      type_q  <= '0;
`ifdef LAUNCHER_BOMB_EN
      bomb_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      gap_q   <= gap_d;
      count_q <= count_d;
      slot_q  <= slot_d;
      rr_q    <= rr_d;
      lgap_q  <= lgap_d;
      init_q  <= init_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xv_q    <= xv_d;
      yv_q    <= yv_d;
      type_q  <= type_d;
`ifdef LAUNCHER_BOMB_EN
      bomb_q  <= bomb_d;
`endif
    end
  end

  assign lif.Initialize = init_q;
  assign lif.X_Pos_Init = x_q;
  assign lif.Y_Pos_Init = y_q;
  assign lif.X_V_Init   = xv_q;
  assign lif.Y_V_Init   = yv_q;
  assign lif.Fruit_Type = type_q;
`ifdef LAUNCHER_BOMB_EN
  assign lif.Is_Bomb    = bomb_q;
`endif
  assign Launch_Count   = count_q;

endmodule

// File: tb/tb_fruit_launcher.sv
// Bench for fruit_launcher: random launches checked against a
// spec-level model (LFSR sequence, slot choice, launch formulas).
module tb_fruit_launcher;
  localparam int N  = 4;
  localparam int GM = 20;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        fe;
  logic        Launch_En;
  logic [15:0] Launch_Count;

  fruit_launcher_if #(.NUM_SLOTS(N)) lif ();

  fruit_launcher #(.NUM_SLOTS(N)) dut (
    .Clk                   (Clk),
    .Reset                 (Reset),
    .frame_clk_rising_edge (fe),
    .Launch_En             (Launch_En),
    .lif                   (lif),
    .Launch_Count          (Launch_Count)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int exp_count = 0;
  int rr_m = 0;
  int have_hs = 0;
  int exp_gap = 0;
  int frames_since = 0;

  logic [15:0] lfsr_m, lfsr_prev;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge Clk) begin
    lfsr_prev <= lfsr_m;
    lfsr_m    <= Reset ? 16'hACE1 : lstep(lfsr_m);
  end

  task automatic cyc(input logic f);
    fe = f;
    @(posedge Clk);
    @(negedge Clk);
    if (f) frames_since++;
  endtask

  // mode: 0 plain, 1 drop Launch_En in ISSUE,
  // 2 drop slot's out_of_screen in ISSUE, 3 reset mid-ISSUE
  task automatic do_launch(input int period, input int mode,
                           input logic [N-1:0] oos,
                           output int waited);
    int ph, slot, lim, j;
    int ex, exv, eyv, ety;
    logic eb;
    logic f, done;
    logic [15:0] L;
    logic [N-1:0] ei;
    lif.out_of_screen = oos;
    slot = -1;
    for (int i = 0; i < N; i++) begin
      j = (rr_m + i) % N;
      if (slot < 0 && oos[j]) slot = j;
    end
    ei = '0;
    ei[slot] = 1'b1;
    waited = 0;
    ph = 0;
    while (lif.Initialize == '0 && waited < 2000) begin
      ph++;
      cyc((ph % period) == 0);
      waited++;
    end
    total++;
    if (lif.Initialize == '0) begin
      bad++;
      $display("FAIL launch_timeout got=0 want=%b", ei);
      return;
    end
    L   = lfsr_prev;
    ex  = 32 + (int'(L[9:0]) % 576);
    exv = 1 + int'(L[14:13]);
    if (ex >= 320) exv = -exv;
    eyv = -(9 + int'(L[12:10]));
    ety = int'(L[15:13]) % 4;
    eb  = (L[7:5] == 3'b000);
`ifdef LAUNCHER_BOMB_EN
    if (eb) ety = 0;
`endif
    total++;
    if (lif.Initialize !== ei) begin
      bad++;
      $display("FAIL init_slot got=%b want=%b",
               lif.Initialize, ei);
    end
    total++;
    if (lif.X_Pos_Init !== ex || lif.Y_Pos_Init !== 511 ||
        lif.X_V_Init !== exv || lif.Y_V_Init !== eyv ||
        lif.Fruit_Type !== 3'(ety) ||
        Launch_Count !== 16'(exp_count)) begin
      bad++;
      $display("FAIL launch_values got x=%0d y=%0d xv=%0d yv=%0d t=%0d c=%0d want x=%0d y=511 xv=%0d yv=%0d t=%0d c=%0d",
               lif.X_Pos_Init, lif.Y_Pos_Init, lif.X_V_Init,
               lif.Y_V_Init, lif.Fruit_Type, Launch_Count,
               ex, exv, eyv, ety, exp_count);
    end
`ifdef LAUNCHER_BOMB_EN
    total++;
    if (lif.Is_Bomb !== eb) begin
      bad++;
      $display("FAIL is_bomb got=%b want=%b", lif.Is_Bomb, eb);
    end
`endif
    if (mode == 1) Launch_En = 1'b0;
    if (mode == 2) lif.out_of_screen[slot] = 1'b0;
    if (mode == 3) begin
      cyc(1'b0);
      cyc(1'b0);
      Reset = 1'b1;
      cyc(1'b1);
      total++;
      if (lif.Initialize !== '0 || Launch_Count !== 16'd0 ||
          lif.X_Pos_Init !== 0 || lif.Fruit_Type !== 3'd0) begin
        bad++;
        $display("FAIL reset_mid_issue got init=%b cnt=%0d x=%0d want 0 0 0",
                 lif.Initialize, Launch_Count, lif.X_Pos_Init);
      end
      Reset = 1'b0;
      exp_count = 0;
      rr_m = 0;
      have_hs = 0;
      return;
    end
    done = 1'b0;
    lim = 0;
    while (!done && lim < 4 * period + 10) begin
      ph++;
      f = ((ph % period) == 0);
      cyc(f);
      lim++;
      if (f) begin
        done = 1'b1;
        total++;
        if (lif.Initialize !== '0 ||
            Launch_Count !== 16'(exp_count + 1)) begin
          bad++;
          $display("FAIL handshake got init=%b cnt=%0d want 0 %0d",
                   lif.Initialize, Launch_Count, exp_count + 1);
        end
        if (have_hs != 0) begin
          total++;
          if (frames_since != exp_gap + 1) begin
            bad++;
            $display("FAIL gap_spacing got=%0d want=%0d",
                     frames_since, exp_gap + 1);
          end
        end
        exp_count++;
        rr_m = (slot + 1) % N;
        exp_gap = GM + int'(L[3:0]);
        have_hs = 1;
        frames_since = 0;
      end else begin
        total++;
        if (lif.Initialize !== ei || lif.X_Pos_Init !== ex ||
            lif.Y_V_Init !== eyv ||
            Launch_Count !== 16'(exp_count)) begin
          bad++;
          $display("FAIL issue_hold got init=%b x=%0d yv=%0d want %b %0d %0d",
                   lif.Initialize, lif.X_Pos_Init, lif.Y_V_Init,
                   ei, ex, eyv);
        end
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL issue_timeout got=%b want=0", lif.Initialize);
    end
  endtask

  task automatic idle_frames(input int frames, input int period,
                             input int cnt0);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < frames * period; k++) begin
      cyc(((k + 1) % period) == 0);
      if (lif.Initialize !== '0) seen = 1'b1;
    end
    total++;
    if (seen || Launch_Count !== 16'(cnt0)) begin
      bad++;
      $display("FAIL idle_hold got seen=%b cnt=%0d want 0 %0d",
               seen, Launch_Count, cnt0);
    end
    have_hs = 0;
  endtask

  task automatic test_reset();
    int w;
    Reset = 1'b1;
    Launch_En = 1'b0;
    lif.out_of_screen = 4'b1111;
    repeat (3) cyc(1'b0);
    total++;
    if (lif.Initialize !== '0 || Launch_Count !== 16'd0 ||
        lif.X_Pos_Init !== 0 || lif.Y_Pos_Init !== 0 ||
        lif.X_V_Init !== 0 || lif.Y_V_Init !== 0 ||
        lif.Fruit_Type !== 3'd0) begin
      bad++;
      $display("FAIL reset_state got init=%b cnt=%0d x=%0d y=%0d want all 0",
               lif.Initialize, Launch_Count, lif.X_Pos_Init,
               lif.Y_Pos_Init);
    end
    exp_count = 0;
    rr_m = 0;
    have_hs = 0;
    Reset = 1'b0;
    Launch_En = 1'b1;
    do_launch(100, 0, 4'b1111, w);
    total++;
    if (w != 3) begin
      bad++;
      $display("FAIL first_latency got=%0d want=3", w);
    end
  endtask

  task automatic test_round_robin();
    int w;
    for (int k = 0; k < 5; k++)
      do_launch($urandom_range(4, 12), 0, 4'b1111, w);
  endtask

  task automatic test_random();
    int w;
    logic [N-1:0] o;
    for (int k = 0; k < 10; k++) begin
      o = N'($urandom_range(1, 15));
      do_launch($urandom_range(4, 16),
                ($urandom_range(0, 3) == 0) ? 2 : 0, o, w);
    end
  endtask

  task automatic test_x_bound(input int target);
    int w, k;
    logic [15:0] v;
    logic found;
    Launch_En = 1'b0;
    lif.out_of_screen = 4'b1111;
    idle_frames(40, 4, exp_count);
    v = lfsr_m;
    found = 1'b0;
    k = 0;
    while (!found && k < 30000) begin
      v = lstep(v);
      k++;
      if (k >= 2 && int'(v[9:0]) == target) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL lfsr_search got=none want=%0d", target);
      return;
    end
    repeat (k - 2) cyc(1'b0);
    Launch_En = 1'b1;
    do_launch(8, 0, 4'b1111, w);
    total++;
    if (target == 0) begin
      if (lif.X_Pos_Init !== 32 || !(lif.X_V_Init > 0)) begin
        bad++;
        $display("FAIL x_left got x=%0d xv=%0d want 32 >0",
                 lif.X_Pos_Init, lif.X_V_Init);
      end
    end else begin
      if (lif.X_Pos_Init !== 607 || !(lif.X_V_Init < 0)) begin
        bad++;
        $display("FAIL x_right got x=%0d xv=%0d want 607 <0",
                 lif.X_Pos_Init, lif.X_V_Init);
      end
    end
  endtask

  task automatic test_no_free();
    int w;
    Launch_En = 1'b1;
    lif.out_of_screen = 4'b0000;
    idle_frames(50, 6, exp_count);
    do_launch(6, 0, 4'b0100, w);
    total++;
    if (w > 6) begin
      bad++;
      $display("FAIL free_slot_delay got=%0d want<=6", w);
    end
  endtask

  task automatic test_en_drop();
    int w;
    Launch_En = 1'b1;
    do_launch(8, 1, 4'b1111, w);
    idle_frames(60, 5, exp_count);
    Launch_En = 1'b1;
    do_launch(8, 0, 4'b1111, w);
    total++;
    if (w != 3) begin
      bad++;
      $display("FAIL resume_latency got=%0d want=3", w);
    end
  endtask

  task automatic test_reset_mid_issue();
    int w;
    Launch_En = 1'b1;
    do_launch(50, 3, 4'b1111, w);
    do_launch(100, 0, 4'b1111, w);
    total++;
    if (w != 3 || Launch_Count !== 16'd1) begin
      bad++;
      $display("FAIL post_reset got lat=%0d cnt=%0d want 3 1",
               w, Launch_Count);
    end
  endtask

  initial begin
    fe = 1'b0;
    Reset = 1'b1;
    Launch_En = 1'b0;
    lif.out_of_screen = '0;
    @(negedge Clk);
    test_reset();
    test_round_robin();
    test_random();
    test_x_bound(0);
    test_x_bound(575);
    test_no_free();
    test_en_drop();
    test_reset_mid_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
